// File: rtl/wb_stage.sv
// Writeback stage of the 3-stage RV32I pipeline: registers the execute result,
// extracts load data, drives the register-file write, forwarding and retire count.
module wb_stage #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                x_valid,
  input  logic [31:0]         x_rd_data,
  input  logic [1:0]          x_addr_lsb,
  input  logic [2:0]          x_funct3,
  input  logic                x_is_load,
  input  logic                x_reg_we,
  input  logic [4:0]          x_rd,
  input  logic [31:0]         dcache_dout,
  input  logic                dcache_stall,
  input  logic                hold,
  output logic                wb_we,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic                fwd_valid,
  output logic [4:0]          fwd_rd,
  output logic [31:0]         fwd_data,
  output logic                misalign,
  output logic [RETIRE_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ALU     = 2'd1,
    LD_WAIT = 2'd2,
    LD_HELD = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic        advance;
  logic        latch_en;
  logic        w_valid;
  logic [31:0] w_rd_data;
  logic [1:0]  w_addr_lsb;
  logic [2:0]  w_funct3;
  logic        w_is_load;
  logic        w_reg_we;
  logic [4:0]  w_rd;
  logic [31:0] ld_latch;
  logic [31:0] ld_word;
  logic [31:0] ld_val;
  logic        ld_bad;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        bad;
  logic        retire;
  logic        data_ready;

  assign advance = !dcache_stall && !hold;
  assign w_valid = (state != EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_rd_data  <= '0;
      w_addr_lsb <= '0;
      w_funct3   <= '0;
      w_is_load  <= 1'b0;
      w_reg_we   <= 1'b0;
      w_rd       <= '0;
    end else if (advance) begin
      w_rd_data  <= x_rd_data;
      w_addr_lsb <= x_addr_lsb;
      w_funct3   <= x_funct3;
      w_is_load  <= x_is_load;
      w_reg_we   <= x_reg_we;
      w_rd       <= x_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  // Load data that arrives during a non-cache hold is captured once, so a later
  // change on dcache_dout cannot corrupt the value still waiting to retire.
  always_comb begin
    state_nx = state;
    latch_en = 1'b0;
    if (advance) begin
      if (!x_valid)       state_nx = EMPTY;
      else if (x_is_load) state_nx = LD_WAIT;
      else                state_nx = ALU;
    end else if (state == LD_WAIT && !dcache_stall) begin
      state_nx = LD_HELD;
      latch_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ld_latch <= '0;
    else if (latch_en) ld_latch <= dcache_dout;
  end

  assign ld_word = (state == LD_HELD) ? ld_latch : dcache_dout;

  always_comb begin
    ld_byte = 8'h00;
    ld_half = 16'h0000;
    case (w_addr_lsb)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = w_addr_lsb[1] ? ld_word[31:16] : ld_word[15:0];
  end

  // Misaligned and illegal loads yield zero so nothing stale leaks out.
  always_comb begin
    ld_val = 32'h0;
    ld_bad = 1'b0;
    case (w_funct3)
      3'd0: ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd4: ld_val = {24'h0, ld_byte};
      3'd1: begin
        if (w_addr_lsb[0]) ld_bad = 1'b1;
        else               ld_val = {{16{ld_half[15]}}, ld_half};
      end
      3'd5: begin
        if (w_addr_lsb[0]) ld_bad = 1'b1;
        else               ld_val = {16'h0, ld_half};
      end
      3'd2: begin
        if (w_addr_lsb != 2'd0) ld_bad = 1'b1;
        else                    ld_val = ld_word;
      end
      default: ld_bad = 1'b1;
    endcase
  end

  assign bad        = w_is_load && ld_bad;
  assign retire     = w_valid && advance;
  assign data_ready = !(state == LD_WAIT && dcache_stall);

  assign wb_we     = retire && w_reg_we && (w_rd != 5'd0) && !bad;
  assign wb_rd     = w_rd;
  assign wb_data   = w_is_load ? ld_val : w_rd_data;
  assign misalign  = retire && w_is_load && bad;
  assign fwd_valid = w_valid && w_reg_we && (w_rd != 5'd0) && !bad && data_ready;
  assign fwd_rd    = w_rd;
  assign fwd_data  = wb_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + RETIRE_W'(1);
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a per-cycle reference model of the W instruction
// plus hand-computed literal expectations for the key scenarios.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_valid;
  logic [31:0] x_rd_data;
  logic [1:0]  x_addr_lsb;
  logic [2:0]  x_funct3;
  logic        x_is_load;
  logic        x_reg_we;
  logic [4:0]  x_rd;
  logic [31:0] dcache_dout;
  logic        dcache_stall;
  logic        hold;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        misalign;
  logic [31:0] retire_cnt;

  int errors = 0;
  int checks = 0;

  wb_stage #(.RETIRE_W(32)) dut (
    .clk(clk), .rst(rst),
    .x_valid(x_valid), .x_rd_data(x_rd_data), .x_addr_lsb(x_addr_lsb),
    .x_funct3(x_funct3), .x_is_load(x_is_load), .x_reg_we(x_reg_we), .x_rd(x_rd),
    .dcache_dout(dcache_dout), .dcache_stall(dcache_stall), .hold(hold),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .misalign(misalign), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the instruction sitting in W, and whether its load word
  // has already been seen on the cache port.
  bit          m_valid, m_load, m_we, m_have;
  logic [31:0] m_rd_data, m_word, m_cnt;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  int          m_lsb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_load = 0; m_we = 0; m_have = 0;
      m_rd_data = 0; m_word = 0; m_cnt = 0; m_rd = 0; m_f3 = 0; m_lsb = 0;
    end else begin
      if (m_valid && !dcache_stall && !hold) m_cnt = m_cnt + 1;
      if (!dcache_stall && !hold) begin
        m_valid = x_valid; m_load = x_is_load; m_we = x_reg_we; m_rd = x_rd;
        m_rd_data = x_rd_data; m_f3 = x_funct3; m_lsb = int'(x_addr_lsb); m_have = 0;
      end else if (m_valid && m_load && !m_have && !dcache_stall) begin
        m_have = 1;
        m_word = dcache_dout;
      end
    end
  end

  // Returns {bad, value} for a load of the given kind from a word.
  function automatic logic [32:0] loadModel(input logic [2:0] f3, input int lsb, input logic [31:0] word);
    logic [31:0] part;
    part = word >> (8 * lsb);
    case (f3)
      3'd0, 3'd4: begin
        part = part & 32'hFF;
        if (f3 == 3'd0 && part >= 32'd128) part = part | 32'hFFFF_FF00;
        return {1'b0, part};
      end
      3'd1, 3'd5: begin
        if (lsb % 2 != 0) return {1'b1, 32'h0};
        part = part & 32'hFFFF;
        if (f3 == 3'd1 && part >= 32'd32768) part = part | 32'hFFFF_0000;
        return {1'b0, part};
      end
      3'd2: return (lsb == 0) ? {1'b0, word} : {1'b1, 32'h0};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [32:0] ld;
    logic [31:0] e_data;
    bit e_bad, e_retire, e_we, e_fwd, e_mis;
    ld       = loadModel(m_f3, m_lsb, m_have ? m_word : dcache_dout);
    e_bad    = m_load && ld[32];
    e_data   = m_load ? ld[31:0] : m_rd_data;
    e_retire = m_valid && !dcache_stall && !hold;
    e_we     = e_retire && m_we && m_rd != 0 && !e_bad;
    e_mis    = e_retire && m_load && e_bad;
    e_fwd    = m_valid && m_we && m_rd != 0 && !e_bad && !(m_load && !m_have && dcache_stall);
    checkOutput("cmp_wb_we", {31'h0, wb_we}, {31'h0, e_we});
    checkOutput("cmp_wb_rd", {27'h0, wb_rd}, {27'h0, m_rd});
    checkOutput("cmp_wb_data", wb_data, e_data);
    checkOutput("cmp_fwd_valid", {31'h0, fwd_valid}, {31'h0, e_fwd});
    checkOutput("cmp_fwd_rd", {27'h0, fwd_rd}, {27'h0, m_rd});
    checkOutput("cmp_fwd_data", fwd_data, e_data);
    checkOutput("cmp_misalign", {31'h0, misalign}, {31'h0, e_mis});
    checkOutput("cmp_retire_cnt", retire_cnt, m_cnt);
  end

  // Drives the execute-side instruction and the cache/hold controls, then settles.
  task automatic applyStimulus(input bit v, input logic [31:0] d, input logic [1:0] lsb,
                               input logic [2:0] f3, input bit ld, input bit we, input logic [4:0] rd,
                               input logic [31:0] dout, input bit stall, input bit hl);
    x_valid = v; x_rd_data = d; x_addr_lsb = lsb; x_funct3 = f3; x_is_load = ld;
    x_reg_we = we; x_rd = rd; dcache_dout = dout; dcache_stall = stall; hold = hl;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input logic [31:0] dout, input bit stall, input bit hl);
    applyStimulus(0, 32'h0, 2'd0, 3'd0, 0, 0, 5'd0, dout, stall, hl);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    bubble(32'h0, 0, 0);
    step();
    checkOutput("reset_wb_we", {31'h0, wb_we}, 32'h0);
    checkOutput("reset_wb_data", wb_data, 32'h0);
    checkOutput("reset_retire_cnt", retire_cnt, 32'h0);
    rst = 1'b0;
    step();

    // ALU op to x5
    applyStimulus(1, 32'h1234, 2'd0, 3'd0, 0, 1, 5'd5, 32'h0, 0, 0);
    step();
    bubble(32'h0, 0, 0);
    checkOutput("alu_wb_we", {31'h0, wb_we}, 32'h1);
    checkOutput("alu_wb_rd", {27'h0, wb_rd}, 32'd5);
    checkOutput("alu_wb_data", wb_data, 32'h1234);
    step();
    checkOutput("alu_retire_cnt", retire_cnt, 32'd1);

    // LB, LBU at lane 3, then LHU upper half
    applyStimulus(1, 32'h0, 2'd3, 3'd0, 1, 1, 5'd6, 32'h80FF_0000, 0, 0);
    step();
    applyStimulus(1, 32'h0, 2'd3, 3'd4, 1, 1, 5'd6, 32'h80FF_0000, 0, 0);
    checkOutput("lb_data", wb_data, 32'hFFFF_FF80);
    checkOutput("lb_we", {31'h0, wb_we}, 32'h1);
    step();
    applyStimulus(1, 32'h0, 2'd2, 3'd5, 1, 1, 5'd6, 32'h80FF_0000, 0, 0);
    checkOutput("lbu_data", wb_data, 32'h0000_0080);
    step();
    applyStimulus(1, 32'h0, 2'd0, 3'd1, 1, 1, 5'd6, 32'h80FF_0000, 0, 0);
    checkOutput("lhu_data", wb_data, 32'h0000_80FF);
    step();
    bubble(32'h0000_8001, 0, 0);
    checkOutput("lh_sext_data", wb_data, 32'hFFFF_8001);
    step();
    checkOutput("loads_retire_cnt", retire_cnt, 32'd5);

    // LW behind three cache-stall cycles
    applyStimulus(1, 32'h0, 2'd0, 3'd2, 1, 1, 5'd7, 32'h0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      bubble(32'h1111_1111, 1, 0);
      checkOutput("stall_fwd_valid", {31'h0, fwd_valid}, 32'h0);
      checkOutput("stall_wb_we", {31'h0, wb_we}, 32'h0);
      step();
    end
    bubble(32'hDEAD_BEEF, 0, 0);
    checkOutput("lw_stall_we", {31'h0, wb_we}, 32'h1);
    checkOutput("lw_stall_data", wb_data, 32'hDEAD_BEEF);
    step();
    checkOutput("lw_stall_we_after", {31'h0, wb_we}, 32'h0);

    // LW whose data arrives during a two-cycle hold
    applyStimulus(1, 32'h0, 2'd0, 3'd2, 1, 1, 5'd8, 32'h0, 0, 0);
    step();
    bubble(32'hDEAD_BEEF, 0, 1);
    checkOutput("hold1_we", {31'h0, wb_we}, 32'h0);
    checkOutput("hold1_data", wb_data, 32'hDEAD_BEEF);
    step();
    bubble(32'h0, 0, 1);
    checkOutput("hold2_we", {31'h0, wb_we}, 32'h0);
    checkOutput("hold2_data", wb_data, 32'hDEAD_BEEF);
    checkOutput("hold2_fwd_valid", {31'h0, fwd_valid}, 32'h1);
    step();
    bubble(32'h0, 0, 0);
    checkOutput("hold_release_we", {31'h0, wb_we}, 32'h1);
    checkOutput("hold_release_data", wb_data, 32'hDEAD_BEEF);
    step();
    checkOutput("hold_retire_cnt", retire_cnt, 32'd7);

    // Misaligned LH, illegal funct3, then a write to x0
    applyStimulus(1, 32'h0, 2'd1, 3'd1, 1, 1, 5'd9, 32'hFFFF_FFFF, 0, 0);
    step();
    applyStimulus(1, 32'h0, 2'd0, 3'd3, 1, 1, 5'd9, 32'hFFFF_FFFF, 0, 0);
    checkOutput("mis_we", {31'h0, wb_we}, 32'h0);
    checkOutput("mis_pulse", {31'h0, misalign}, 32'h1);
    checkOutput("mis_data", wb_data, 32'h0);
    step();
    applyStimulus(1, 32'h55, 2'd0, 3'd0, 0, 1, 5'd0, 32'h0, 0, 0);
    checkOutput("illegal_pulse", {31'h0, misalign}, 32'h1);
    checkOutput("mis_retire_cnt", retire_cnt, 32'd8);
    step();
    bubble(32'h0, 0, 0);
    checkOutput("x0_we", {31'h0, wb_we}, 32'h0);
    checkOutput("x0_misalign", {31'h0, misalign}, 32'h0);
    step();
    checkOutput("x0_retire_cnt", retire_cnt, 32'd10);

    // Reset while a load sits latched in W
    applyStimulus(1, 32'h0, 2'd0, 3'd2, 1, 1, 5'd10, 32'h0, 0, 0);
    step();
    bubble(32'hCAFE_F00D, 0, 1);
    step();
    rst = 1'b1;
    #1;
    checkOutput("rst_wb_we", {31'h0, wb_we}, 32'h0);
    checkOutput("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
    checkOutput("rst_wb_data", wb_data, 32'h0);
    checkOutput("rst_fwd_valid", {31'h0, fwd_valid}, 32'h0);
    checkOutput("rst_retire_cnt", retire_cnt, 32'h0);
    step();
    rst = 1'b0;
    bubble(32'hCAFE_F00D, 0, 0);
    checkOutput("post_rst_we", {31'h0, wb_we}, 32'h0);
    step();
    checkOutput("post_rst_cnt", retire_cnt, 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 3-stage RV32I pipeline, directly downstream of the execute/memory stage. It registers the execute result, aligns and sign- or zero-extends data returning from the synchronous-read data cache, and issues the register-file write. It latches cache read data across pipeline holds, provides a forwarding port back to execute, and counts retired instructions.

## Interface

Parameters:
- `RETIRE_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `x_valid`  in  1  execute stage holds a real instruction (0 = bubble).
- `x_rd_data`  in  32  execute-stage writeback value for non-loads (ALU, PC+4, or branch target).
- `x_addr_lsb`  in  2  ALU_out[1:0] of the load address.
- `x_funct3`  in  3  instruction funct3.
- `x_is_load`  in  1  instruction is a load.
- `x_reg_we`  in  1  instruction writes rd.
- `x_rd`  in  5  destination register.
- `dcache_dout`  in  32  word read from the data cache (address word-aligned).
- `dcache_stall`  in  1  data cache is busy; the whole pipeline holds.
- `hold`  in  1  non-cache pipeline hold, for example from the instruction cache.
- `wb_we`  out  1  register-file write enable.
- `wb_rd`  out  5  register-file write address.
- `wb_data`  out  32  register-file write data.
- `fwd_valid`  out  1  `fwd_rd`/`fwd_data` are usable for bypass.
- `fwd_rd`  out  5  register being written by the instruction in W.
- `fwd_data`  out  32  value being written.
- `misalign`  out  1  one-cycle pulse when a misaligned or illegal load retires.
- `retire_cnt`  out  RETIRE_W  count of retired valid instructions.

## Operation

- `advance = !dcache_stall && !hold`.
- On a rising edge with `advance=1`, W registers capture `x_*`. `w_valid` is set to `x_valid`. Without `advance`, all W registers hold.
- State machine:
  - EMPTY: `w_valid=0`.
  - ALU: valid non-load.
  - LD_WAIT: valid load whose data comes live from `dcache_dout`.
  - LD_HELD: valid load whose data sits in the internal 32-bit latch.
- Transitions:
  - Any state with `advance` goes to the state selected by the incoming instruction.
  - LD_WAIT with `dcache_stall=0 && hold=1`: latch `dcache_dout` and go to LD_HELD.
  - LD_WAIT with `dcache_stall=1`: stay in LD_WAIT; nothing is latched.
  - LD_HELD with `advance=0`: stay; the latch is never overwritten.
- Load data source: `dcache_dout` in LD_WAIT, the latch in LD_HELD.
- Load extraction by `w_funct3` and `w_addr_lsb`:
  - 0 (LB) / 4 (LBU): byte at lane `lsb`, sign- or zero-extended.
  - 1 (LH) / 5 (LHU): lsb 0 gives bits [15:0], lsb 2 gives bits [31:16], sign- or zero-extended. lsb 1 or 3 is misaligned.
  - 2 (LW): lsb 0 gives the full word. Any other lsb is misaligned.
  - Funct3 3, 6, 7 are illegal.
- Misaligned or illegal loads produce value 0. They also force write suppression.
- `retire = w_valid && advance`.
- `wb_we = retire && w_reg_we && (w_rd != 0) && !bad`, where `bad` is the misaligned/illegal condition.
- `wb_rd = w_rd`. `wb_data` is the extracted load value for loads, otherwise `w_rd_data`.
- `misalign = retire && w_is_load && bad`.
- Forwarding:
  - `fwd_valid = w_valid && w_reg_we && (w_rd != 0) && !bad && data_ready`.
  - `data_ready` is 0 only in LD_WAIT while `dcache_stall=1`.
  - `fwd_data` equals `wb_data`.
- `retire_cnt` increments by 1 on each retire, including misaligned loads. It wraps modulo 2^RETIRE_W.

## Timing

- Reset (asynchronous):
  - State EMPTY, `w_valid=0`, latch 0, `retire_cnt=0`.
  - All outputs are combinationally 0: `wb_we`, `wb_rd`, `wb_data`, `fwd_*`, `misalign`.
- Latency: an instruction captured at edge N is in W during cycle N+1. With no stall, `wb_we` is asserted in cycle N+1 and the register file commits at edge N+2.
- Load data appears on `dcache_dout` in the first W cycle with `dcache_stall=0`.
- `wb_we`, `misalign`, and the `retire_cnt` increment are outputs of the cycle in which `advance=1`. One retire per instruction; never repeated during holds.
- `hold` and `dcache_stall` high in the same cycle: treat as a stall; nothing is latched.
- Reset asserted mid-hold: the latch and the W instruction are discarded; no write occurs.

## Test plan

- ALU op: `x_rd_data=0x1234`, `rd=5`, `reg_we=1`, no stalls -> next cycle `wb_we=1`, `wb_rd=5`, `wb_data=0x1234`, `retire_cnt=1`.
- LB, lsb=3, `dcache_dout=0x80FF_0000` -> `wb_data=0xFFFF_FF80`. LBU with the same inputs -> `0x0000_0080`. LHU, lsb=2 -> `0x0000_80FF`.
- LW, 3 cycles of `dcache_stall=1` then `dcache_dout=0xDEADBEEF` -> `fwd_valid=0` during the stall; `wb_we=1` with `0xDEADBEEF` only in the first non-stall cycle.
- LW data arrives with `hold=1` for 2 cycles while `dcache_dout` then changes to `0x0` -> `wb_data` remains `0xDEADBEEF` throughout; a single `wb_we` pulse when `hold` drops.
- LH, lsb=1 -> `wb_we=0`, `misalign=1` for one cycle, `retire_cnt` increments. Write to `rd=0` -> `wb_we=0`, `misalign=0`.
- Assert `rst` during LD_HELD -> all outputs 0 immediately, `retire_cnt=0`, no write after release.
